ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. It consumes the latched register operands (ReadData1/ReadData2) for MULT, MULTU, DIV and DIVU, and computes one result bit per cycle into the architectural HI/LO registers. It also services MTHI/MTLO writes and MFHI/MFLO reads. While a result is pending, it raises a stall that holds dependent instructions in ID.

## Interface
- WIDTH, 32, operand and HI/LO width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  valid mult/div op present in EX this cycle
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  input  WIDTH  multiplicand / dividend (ID/EX ReadData1_out)
- rt_val  input  WIDTH  multiplier / divisor (ID/EX ReadData2_out)
- flush  input  1  abort the in-flight op (branch/exception squash)
- wr_hi, wr_lo  input  1 each  MTHI/MTLO write strobes
- wr_data  input  WIDTH  MTHI/MTLO data
- hilo_use  input  1  instruction in ID reads HI/LO or is another mult/div
- hi_out, lo_out  output  WIDTH  architectural HI/LO
- busy  output  1  op in flight
- done  output  1  one-cycle pulse after HI/LO update
- stall  output  1  busy & hilo_use (combinational)

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE: on start, latch operands and op, clear the 5-bit iteration counter, then go to RUN.
  - Signed ops latch absolute values and record the result signs.
  - Quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
- RUN: one iteration per cycle.
  - MULT: shift-add into a 2·WIDTH accumulator.
  - DIV: restoring shift-subtract.
  - Counter increments each cycle. When the counter reaches WIDTH-1, go to FIX.
- FIX: apply two's-complement negation per the recorded signs and write HI/LO, then return to IDLE.
  - MULT: HI = upper half, LO = lower half.
  - DIV: LO = quotient, HI = remainder.
- All arithmetic is modulo 2^WIDTH per half. There is no overflow trap.
- Divide by zero (any signedness): LO = all ones, HI = rs_val. Normal latency is kept.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- start while busy is ignored; upstream stall guarantees this does not occur.
- flush while busy: return to IDLE at the next edge. HI/LO are unchanged, no done pulse, and busy drops after that edge. A flush in IDLE has no effect. If flush and start are asserted together in IDLE, start is ignored.
- wr_hi/wr_lo in IDLE update HI/LO at the edge; while busy they are ignored.
- wr_hi/wr_lo together with start in IDLE: the write lands; the later FIX overwrites it.
- hi_out/lo_out always reflect the registers. MFHI/MFLO correctness relies on stall.

## Timing
- start sampled at edge E0.
- busy is high from E0 through E33.
- RUN iterations occur at edges E1..E32; FIX at E33.
- HI/LO are updated at E33. done is high during the cycle after E33.
- Latency is 33 cycles from start to valid HI/LO. Back-to-back start is accepted in the cycle after E33.
- stall is combinational and is never asserted when busy = 0.
- Reset (async, any time, including mid-op):
  - state = IDLE, counter = 0
  - busy = 0, done = 0, stall = 0
  - hi_out = 0, lo_out = 0
  - Reset takes effect immediately and discards any in-flight op.

## Structure
- Shared package muldiv_pkg holds the op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), the state enum, and the WIDTH default.
- Single module: the datapath is small, so no sub-module is needed. The sign-fix negation is a package function.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001 at E33; done pulses for exactly one cycle; busy is high for 33 cycles.
- MULT −3 × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. DIVU 100 / 7 → LO = 14, HI = 2.
- DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- DIV 0x12345678 / 0 → LO = 0xFFFFFFFF, HI = 0x12345678 after 33 cycles.
- Flush at cycle 10 of a MULT with HI/LO preloaded to 0xAAAA_AAAA / 0x5555_5555 via MTHI/MTLO → values unchanged, no done, busy low at the next edge. hilo_use = 1 while busy → stall = 1.
- rst_n pulsed low at cycle 15 of a DIV → all outputs are zero immediately; a subsequent start completes normally with the correct result.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op encodings,
// FSM states, datapath width and the sign-fix negation helpers.
package muldiv_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    cond_neg = en ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] v,
                                                       input logic en);
    cond_neg_wide = en ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Operand, HI/LO write and result bundle between the EX stage and the
// multiply/divide unit.
interface ex_muldiv_unit_if;

  logic                          start;
  logic [1:0]                    op;
  logic [muldiv_pkg::WIDTH-1:0]  rs_val;
  logic [muldiv_pkg::WIDTH-1:0]  rt_val;
  logic                          flush;
  logic                          wr_hi;
  logic                          wr_lo;
  logic [muldiv_pkg::WIDTH-1:0]  wr_data;
  logic                          hilo_use;
  logic [muldiv_pkg::WIDTH-1:0]  hi_out;
  logic [muldiv_pkg::WIDTH-1:0]  lo_out;
  logic                          busy;
  logic                          done;
  logic                          stall;

  modport master (
    output start, op, rs_val, rt_val, flush, wr_hi, wr_lo, wr_data, hilo_use,
    input  hi_out, lo_out, busy, done, stall
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush, wr_hi, wr_lo, wr_data, hilo_use,
    output hi_out, lo_out, busy, done, stall
  );

endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit owning the HI/LO
// registers; one result bit per cycle, sign fix-up in a final cycle.
module ex_muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  ex_muldiv_unit_if.slave mdu
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opb_q;
  logic                 is_div_q;
  logic                 neg_q_q;
  logic                 neg_r_q;
  logic                 dz_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 sgn_s;
  logic [WIDTH:0]       mul_sum_s;
  logic [2*WIDTH:0]     div_shift_s;
  logic [WIDTH:0]       div_trial_s;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s;
  logic [WIDTH-1:0]     rem_s;

  // One multiply or divide iteration plus the fixed-up results for FIX.
  always_comb begin
    sgn_s       = ~mdu.op[0];
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q & {WIDTH{acc_q[0]}}};
    div_shift_s = {acc_q, 1'b0};
    div_trial_s = div_shift_s[2*WIDTH:WIDTH] - {1'b0, opb_q};
    if (!is_div_q) begin
      acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
    end else if (!div_trial_s[WIDTH]) begin
      acc_d = {div_trial_s[WIDTH-1:0], div_shift_s[WIDTH-1:1], 1'b1};
    end else begin
      acc_d = div_shift_s[2*WIDTH-1:0];
    end
    prod_s = cond_neg_wide(acc_q, neg_q_q);
    // Remainder of a zero divisor is |rs|; negating by sign(rs) restores rs.
    quo_s  = dz_q ? {WIDTH{1'b1}} : cond_neg(acc_q[WIDTH-1:0], neg_q_q);
    rem_s  = cond_neg(acc_q[2*WIDTH-1:WIDTH], neg_r_q);
  end

  // Control FSM with registered HI/LO, busy and done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      acc_q    <= {(2*WIDTH){1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mdu.wr_hi) hi_q <= mdu.wr_data;
          if (mdu.wr_lo) lo_q <= mdu.wr_data;
          if (mdu.start && !mdu.flush) begin
            is_div_q <= mdu.op[1];
            neg_q_q  <= sgn_s & (mdu.rs_val[WIDTH-1] ^ mdu.rt_val[WIDTH-1]);
            neg_r_q  <= sgn_s & mdu.rs_val[WIDTH-1];
            dz_q     <= (mdu.rt_val == {WIDTH{1'b0}});
            cnt_q    <= {CNT_W{1'b0}};
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
            if (mdu.op[1]) begin
              acc_q <= {{WIDTH{1'b0}}, cond_neg(mdu.rs_val, sgn_s & mdu.rs_val[WIDTH-1])};
              opb_q <= cond_neg(mdu.rt_val, sgn_s & mdu.rt_val[WIDTH-1]);
            end else begin
              acc_q <= {{WIDTH{1'b0}}, cond_neg(mdu.rt_val, sgn_s & mdu.rt_val[WIDTH-1])};
              opb_q <= cond_neg(mdu.rs_val, sgn_s & mdu.rs_val[WIDTH-1]);
            end
          end
        end
        ST_RUN: begin
          if (mdu.flush) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_LAST) state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
          if (!mdu.flush) begin
            done_q <= 1'b1;
            if (is_div_q) begin
              hi_q <= rem_s;
              lo_q <= quo_s;
            end else begin
              hi_q <= prod_s[2*WIDTH-1:WIDTH];
              lo_q <= prod_s[WIDTH-1:0];
            end
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mdu.hi_out = hi_q;
  assign mdu.lo_out = lo_q;
  assign mdu.busy   = busy_q;
  assign mdu.done   = done_q;
  assign mdu.stall  = busy_q & mdu.hilo_use;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed test-plan cases, flush,
// mid-op reset, back-to-back and random ops against a behavioural model.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [63:0] sb_q[$];

  ex_muldiv_unit_if mdu_if();

  ex_muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mdu   (mdu_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] rs,
                                        input logic [31:0] rt);
    longint p;
    int     q;
    int     r;
    case (op)
      OP_MULT: begin
        p = longint'($signed(rs)) * longint'($signed(rt));
        model = p;
      end
      OP_MULTU: model = {32'd0, rs} * {32'd0, rt};
      OP_DIV: begin
        if (rt == 32'd0) model = {rs, 32'hFFFF_FFFF};
        else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) model = {32'd0, 32'h8000_0000};
        else begin
          q = $signed(rs) / $signed(rt);
          r = $signed(rs) % $signed(rt);
          model = {r, q};
        end
      end
      default: begin
        if (rt == 32'd0) model = {rs, 32'hFFFF_FFFF};
        else model = {rs % rt, rs / rt};
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit chk_pulse);
    logic [63:0] exp_v;
    int busy_cnt;
    int lat;
    bit got;
    sb_q.push_back({exp_hi, exp_lo});
    mdu_if.op     = op;
    mdu_if.rs_val = rs;
    mdu_if.rt_val = rt;
    mdu_if.start  = 1'b1;
    @(posedge clk); #1;
    mdu_if.start = 1'b0;
    busy_cnt = 0;
    lat = 0;
    got = 1'b0;
    if (mdu_if.busy) busy_cnt++;
    for (int c = 1; c <= 40 && !got; c++) begin
      @(posedge clk); #1;
      if (mdu_if.done) begin
        got = 1'b1;
        lat = c;
      end else if (mdu_if.busy) begin
        busy_cnt++;
      end
    end
    exp_v = sb_q.pop_front();
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL timeout op=%0d rs=%h rt=%h: no done within 40 cycles", op, rs, rt);
    end else begin
      n_vec++;
      if (mdu_if.hi_out !== exp_v[63:32]) begin
        n_err++;
        $display("FAIL hi op=%0d rs=%h rt=%h: got %h want %h", op, rs, rt, mdu_if.hi_out, exp_v[63:32]);
      end
      n_vec++;
      if (mdu_if.lo_out !== exp_v[31:0]) begin
        n_err++;
        $display("FAIL lo op=%0d rs=%h rt=%h: got %h want %h", op, rs, rt, mdu_if.lo_out, exp_v[31:0]);
      end
      n_vec++;
      if (lat !== 33) begin
        n_err++;
        $display("FAIL latency op=%0d: got %0d want 33", op, lat);
      end
      n_vec++;
      if (busy_cnt !== 33 || mdu_if.busy !== 1'b0) begin
        n_err++;
        $display("FAIL busy_len op=%0d: got %0d cycles (busy now %b) want 33 (0)", op, busy_cnt, mdu_if.busy);
      end
    end
    if (chk_pulse) begin
      @(posedge clk); #1;
      n_vec++;
      if (mdu_if.done !== 1'b0) begin
        n_err++;
        $display("FAIL done_pulse: done still %b one cycle later, want 0", mdu_if.done);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if ({mdu_if.busy, mdu_if.done, mdu_if.stall} !== 3'b000 ||
        mdu_if.hi_out !== 32'd0 || mdu_if.lo_out !== 32'd0) begin
      n_err++;
      $display("FAIL reset: busy/done/stall=%b%b%b hi=%h lo=%h want 000 0 0",
               mdu_if.busy, mdu_if.done, mdu_if.stall, mdu_if.hi_out, mdu_if.lo_out);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    run_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_op(OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
    run_op(OP_DIV,   32'h1234_5678, 32'd0,         32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
  endtask

  task automatic test_flush();
    bit saw_done;
    mdu_if.wr_hi   = 1'b1;
    mdu_if.wr_data = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    mdu_if.wr_hi   = 1'b0;
    mdu_if.wr_lo   = 1'b1;
    mdu_if.wr_data = 32'h5555_5555;
    @(posedge clk); #1;
    mdu_if.wr_lo = 1'b0;
    mdu_if.hilo_use = 1'b1;
    n_vec++;
    if (mdu_if.hi_out !== 32'hAAAA_AAAA || mdu_if.lo_out !== 32'h5555_5555 || mdu_if.stall !== 1'b0) begin
      n_err++;
      $display("FAIL mthi_mtlo: hi=%h lo=%h stall=%b want aaaaaaaa 55555555 0",
               mdu_if.hi_out, mdu_if.lo_out, mdu_if.stall);
    end
    mdu_if.op     = OP_MULT;
    mdu_if.rs_val = 32'd3;
    mdu_if.rt_val = 32'd5;
    mdu_if.start  = 1'b1;
    @(posedge clk); #1;
    mdu_if.start   = 1'b0;
    mdu_if.wr_hi   = 1'b1;
    mdu_if.wr_data = 32'h1234_5678;
    n_vec++;
    if (mdu_if.stall !== 1'b1 || mdu_if.busy !== 1'b1) begin
      n_err++;
      $display("FAIL stall_busy: stall=%b busy=%b want 1 1", mdu_if.stall, mdu_if.busy);
    end
    @(posedge clk); #1;
    mdu_if.wr_hi = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    mdu_if.flush = 1'b1;
    @(posedge clk); #1;
    mdu_if.flush = 1'b0;
    n_vec++;
    if (mdu_if.busy !== 1'b0 || mdu_if.stall !== 1'b0 ||
        mdu_if.hi_out !== 32'hAAAA_AAAA || mdu_if.lo_out !== 32'h5555_5555) begin
      n_err++;
      $display("FAIL flush: busy=%b stall=%b hi=%h lo=%h want 0 0 aaaaaaaa 55555555",
               mdu_if.busy, mdu_if.stall, mdu_if.hi_out, mdu_if.lo_out);
    end
    saw_done = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      saw_done |= mdu_if.done;
    end
    n_vec++;
    if (saw_done !== 1'b0 || mdu_if.hi_out !== 32'hAAAA_AAAA || mdu_if.lo_out !== 32'h5555_5555) begin
      n_err++;
      $display("FAIL flush_after: done_seen=%b hi=%h lo=%h want 0 aaaaaaaa 55555555",
               saw_done, mdu_if.hi_out, mdu_if.lo_out);
    end
    mdu_if.flush = 1'b1;
    mdu_if.start = 1'b1;
    @(posedge clk); #1;
    mdu_if.flush = 1'b0;
    mdu_if.start = 1'b0;
    n_vec++;
    if (mdu_if.busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_start_idle: busy=%b want 0", mdu_if.busy);
    end
  endtask

  task automatic test_reset_mid_op();
    mdu_if.op     = OP_DIV;
    mdu_if.rs_val = 32'd100;
    mdu_if.rt_val = 32'd7;
    mdu_if.start  = 1'b1;
    @(posedge clk); #1;
    mdu_if.start = 1'b0;
    repeat (14) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({mdu_if.busy, mdu_if.done, mdu_if.stall} !== 3'b000 ||
        mdu_if.hi_out !== 32'd0 || mdu_if.lo_out !== 32'd0) begin
      n_err++;
      $display("FAIL reset_mid_op: busy/done/stall=%b%b%b hi=%h lo=%h want 000 0 0",
               mdu_if.busy, mdu_if.done, mdu_if.stall, mdu_if.hi_out, mdu_if.lo_out);
    end
    #2;
    rst_n = 1'b1;
    mdu_if.hilo_use = 1'b0;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [63:0] e;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      rs = $urandom;
      rt = $urandom;
      if (i == 0) rt = 32'd0;
      if (i % 3 == 1) rt = $urandom_range(1, 9);
      e = model(op, rs, rt);
      run_op(op, rs, rt, e[63:32], e[31:0], 1'b0);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    mdu_if.start    = 1'b0;
    mdu_if.op       = 2'b00;
    mdu_if.rs_val   = 32'd0;
    mdu_if.rt_val   = 32'd0;
    mdu_if.flush    = 1'b0;
    mdu_if.wr_hi    = 1'b0;
    mdu_if.wr_lo    = 1'b0;
    mdu_if.wr_data  = 32'd0;
    mdu_if.hilo_use = 1'b0;
    test_reset();
    test_directed();
    test_flush();
    test_reset_mid_op();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
